// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns one load/store request into a single word-aligned
// data-bus transaction, then extends the returned lane or reports a fault.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic          bad_req;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] data);
        logic [31:0] lane;
        lane = data >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{lane[7]}}, lane[7:0]};
            3'b001:  return {{16{lane[15]}}, lane[15:0]};
            3'b100:  return {24'h0, lane[7:0]};
            3'b101:  return {16'h0, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    // funct3[1:0] encodes the access size for every legal load and store code
    always_comb begin
        bad_req   = 1'b0;
        req_be    = 4'b1111;
        req_wdata = wdata;
        if (req_we) begin
            if (req_funct3 >= 3'b011) bad_req = 1'b1;
        end else begin
            if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
                bad_req = 1'b1;
        end
        case (req_funct3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_be    = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{wdata[15:0]}};
                if (addr[0]) bad_req = 1'b1;
            end
            default: begin
                if (addr[1:0] != 2'b00) bad_req = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        stall       = 1'b0;
        misalign    = 1'b0;
        bus_req     = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (bad_req) begin
                        misalign = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = req_be;
                        bus_wdata_d = req_wdata;
                        funct3_d    = req_funct3;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                        rdata_d     = 32'h0;
                        fault_d     = 1'b0;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // An ack in the final allowed cycle still wins over the timeout
                if (bus_ack) begin
                    state_d = DONE;
                    fault_d = bus_err;
                    rdata_d = (bus_err || bus_we_q) ? 32'h0 : extract(funct3_q, off_q, bus_rdata);
                end else if (cnt_q == LAST_CYCLE) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            funct3_q    <= 3'h0;
            off_q       <= 2'h0;
            rdata_q     <= 32'h0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign rdata        = rdata_q;
    assign access_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random accesses
// compared against an arithmetic model of RV32I load/store behaviour.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign),
        .access_fault(access_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit exceeded");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int sizeOf(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit isLegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (we) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!ok) return 1'b0;
        return (a % sizeOf(f3)) == 0;
    endfunction

    function automatic logic [3:0] expBe(input logic [2:0] f3, input logic [31:0] a);
        int mask;
        mask = ((1 << sizeOf(f3)) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] wd);
        case (sizeOf(f3))
            1:       return (wd % 256) * 32'h0101_0101;
            2:       return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
        longint lane, range, v;
        int bytes;
        bytes = sizeOf(f3);
        lane  = longint'(rd) / (longint'(1) << (8 * (a % 4)));
        if (bytes == 4) return lane[31:0];
        range = longint'(1) << (8 * bytes);
        v = lane % range;
        if (f3[2] == 1'b0 && v >= range / 2) v = v - range;
        return v[31:0];
    endfunction

    // ---------------- helpers ----------------
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, ".idle_done"}, done, 1'b0);
        checkOutput({tag, ".idle_busreq"}, bus_req, 1'b0);
        checkOutput({tag, ".idle_stall"}, stall, 1'b0);
        checkOutput({tag, ".idle_misalign"}, misalign, 1'b0);
        nextCycle();
    endtask

    // One full request; k = BUSY cycle (1-based) in which ack is given, 0 = never
    task automatic applyStimulus(input string tag, input bit we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd, input int k,
                                 input logic [31:0] rd, input bit err);
        bit legal, finished, timed_out, exp_fault;
        int cycles;
        logic [31:0] exp_rdata;
        legal = isLegal(we, f3, a);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        addr       = a;
        wdata      = wd;
        bus_ack    = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".accept_stall"}, stall, legal);
        checkOutput({tag, ".accept_misalign"}, misalign, !legal);
        checkOutput({tag, ".accept_busreq"}, bus_req, 1'b0);
        nextCycle();
        req_valid  = 1'b0;
        addr       = $urandom;
        wdata      = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        if (!legal) begin
            checkIdle(tag);
            return;
        end
        cycles   = 0;
        finished = 1'b0;
        while (!finished) begin
            cycles++;
            bus_ack   = (cycles == k);
            bus_rdata = (cycles == k) ? rd : $urandom;
            bus_err   = (cycles == k) ? err : 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput({tag, ".busy_busreq"}, bus_req, 1'b1);
            checkOutput({tag, ".busy_stall"}, stall, 1'b1);
            checkOutput({tag, ".busy_done"}, done, 1'b0);
            checkOutput({tag, ".bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
            checkOutput({tag, ".bus_be"}, bus_be, expBe(f3, a));
            checkOutput({tag, ".bus_we"}, bus_we, we);
            if (we) checkOutput({tag, ".bus_wdata"}, bus_wdata, expWdata(f3, wd));
            if (cycles == k || cycles == TIMEOUT) finished = 1'b1;
            nextCycle();
        end
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        timed_out = !(k >= 1 && k <= TIMEOUT);
        exp_fault = timed_out || err;
        exp_rdata = (exp_fault || we) ? 32'h0 : expLoad(f3, a, rd);
        // a request presented during the completion cycle must be ignored
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'b0;
        req_funct3 = 3'b010;
        addr      = 32'h0000_0100;
        @(negedge clk);
        checkOutput({tag, ".done"}, done, 1'b1);
        checkOutput({tag, ".done_stall"}, stall, 1'b0);
        checkOutput({tag, ".done_busreq"}, bus_req, 1'b0);
        checkOutput({tag, ".rdata"}, rdata, exp_rdata);
        checkOutput({tag, ".fault"}, access_fault, exp_fault);
        nextCycle();
        req_valid = 1'b0;
        checkIdle(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        addr       = 32'h0;
        wdata      = 32'h0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'h0;
        bus_err    = 1'b0;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset.bus_req", bus_req, 1'b0);
        checkOutput("reset.done", done, 1'b0);
        checkOutput("reset.fault", access_fault, 1'b0);
        checkOutput("reset.rdata", rdata, 32'h0);
        checkOutput("reset.bus_addr", bus_addr, 32'h0);
        checkOutput("reset.bus_be", bus_be, 4'h0);
        checkOutput("reset.bus_wdata", bus_wdata, 32'h0);
        checkOutput("reset.bus_we", bus_we, 1'b0);
        nextCycle();
        rst = 1'b0;

        // idle with no request, plus a stray ack that must be ignored
        addr    = 32'h0000_0003;
        bus_ack = 1'b1;
        bus_err = 1'b1;
        @(negedge clk);
        checkOutput("idle.stall", stall, 1'b0);
        checkOutput("idle.misalign", misalign, 1'b0);
        nextCycle();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        checkIdle("stray_ack");

        applyStimulus("lb_1003", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h80FF_1234, 1'b0);
        applyStimulus("sh_2002", 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 1, 32'h0, 1'b0);
        applyStimulus("lw_3001", 1'b0, 3'b010, 32'h0000_3001, 32'h0, 1, 32'h0, 1'b0);
        applyStimulus("lhu_timeout", 1'b0, 3'b101, 32'h0000_4000, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus("lw_ack_last", 1'b0, 3'b010, 32'h0000_4100, 32'h0, TIMEOUT,
                      32'hCAFE_F00D, 1'b0);

        // reset in the second BUSY cycle aborts the access
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        addr       = 32'h0000_6000;
        nextCycle();
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstbusy.busy1", bus_req, 1'b1);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstbusy.busy2", bus_req, 1'b1);
        nextCycle();
        rst       = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("rstbusy.busreq", bus_req, 1'b0);
        checkOutput("rstbusy.done", done, 1'b0);
        checkOutput("rstbusy.bus_addr", bus_addr, 32'h0);
        checkOutput("rstbusy.bus_be", bus_be, 4'h0);
        nextCycle();
        bus_ack = 1'b0;
        checkIdle("rstbusy_late_ack");

        applyStimulus("lw_err", 1'b0, 3'b010, 32'h0000_7000, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
        applyStimulus("lbu_5001", 1'b0, 3'b100, 32'h0000_5001, 32'h0, 1, 32'h0000_9A00, 1'b0);
        applyStimulus("sb_3", 1'b1, 3'b000, 32'h0000_8003, 32'h1234_5677, 3, 32'h0, 1'b0);
        applyStimulus("lh_neg", 1'b0, 3'b001, 32'h0000_8002, 32'h0, 1, 32'h8001_0000, 1'b0);
        applyStimulus("ld_illegal", 1'b0, 3'b110, 32'h0000_9000, 32'h0, 1, 32'h0, 1'b0);
        applyStimulus("st_illegal", 1'b1, 3'b100, 32'h0000_9000, 32'h0, 1, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [2:0]  rf3;
            int          rk;
            ra  = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            rf3 = 3'($urandom_range(0, 7));
            rk  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            applyStimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), rf3, ra,
                          $urandom, rk, $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
